// File: rtl/cpu_control_unit_if.sv
// Signal bundle between the CPU control sequencer and its environment
// (program memory handshake, IR opcode, datapath flags and control strobes).
interface cpu_control_unit_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run;
  logic [3:0]       ir_op;
  logic             zero_flag;
  logic             mem_ready;
  logic             mem_re;
  logic             ir_re;
  logic             opr_re;
  logic             pc_inc;
  logic             pc_load;
  logic             acc_we;
  logic [2:0]       alu_op;
  logic             out_we;
  logic             halted;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, ir_op, zero_flag, mem_ready,
    input  mem_re, ir_re, opr_re, pc_inc, pc_load, acc_we, alu_op, out_we,
    input  halted, illegal, bus_err, instr_cnt
  );

  modport slave (
    input  run, ir_op, zero_flag, mem_ready,
    output mem_re, ir_re, opr_re, pc_inc, pc_load, acc_we, alu_op, out_we,
    output halted, illegal, bus_err, instr_cnt
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: steps through memory
// fetches, operand loads and per-opcode execute strobes.
module cpu_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD_IR, S_DECODE, S_OPFETCH, S_OPLOAD, S_EXEC, S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal, bus_err;
  logic             mem_wait, timeout, needs_operand;

  assign needs_operand = bus.ir_op inside {[4'h1:4'h6], 4'h8, 4'h9};
  assign mem_wait      = (state == S_FETCH) || (state == S_OPFETCH);
  // wait_cnt holds (fetch cycle - 1), so the last accepted cycle is MEM_TIMEOUT
  assign timeout       = mem_wait && !bus.mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wait_cnt <= mem_wait ? wait_cnt + 8'd1 : '0;
      if (timeout) bus_err <= 1'b1;
      if (state == S_EXEC) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
        if (bus.ir_op inside {[4'hB:4'hE]}) illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.run) state_nxt = S_FETCH;
      S_FETCH:   if (bus.mem_ready) state_nxt = S_LOAD_IR;
                 else if (timeout)  state_nxt = S_HALT;
      S_LOAD_IR: state_nxt = S_DECODE;
      S_DECODE:  state_nxt = needs_operand ? S_OPFETCH : S_EXEC;
      S_OPFETCH: if (bus.mem_ready) state_nxt = S_OPLOAD;
                 else if (timeout)  state_nxt = S_HALT;
      S_OPLOAD:  state_nxt = S_EXEC;
      S_EXEC:    if (bus.ir_op == 4'hF) state_nxt = S_HALT;
                 else if (bus.run)      state_nxt = S_FETCH;
                 else                   state_nxt = S_IDLE;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_re  = 1'b0;
    bus.ir_re   = 1'b0;
    bus.opr_re  = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_load = 1'b0;
    bus.acc_we  = 1'b0;
    bus.alu_op  = 3'd0;
    bus.out_we  = 1'b0;
    bus.halted  = 1'b0;
    case (state)
      S_FETCH, S_OPFETCH: bus.mem_re = 1'b1;
      S_LOAD_IR: begin
        bus.ir_re  = 1'b1;
        bus.pc_inc = 1'b1;
      end
      S_OPLOAD: begin
        bus.opr_re = 1'b1;
        bus.pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (bus.ir_op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            bus.acc_we = 1'b1;
            bus.alu_op = 3'(bus.ir_op - 4'd1);
          end
          4'h8:    bus.pc_load = 1'b1;
          4'h9:    bus.pc_load = bus.zero_flag;
          4'hA:    bus.out_we  = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.illegal   = illegal;
  assign bus.bus_err   = bus_err;
  assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: opcode vector table with a
// per-cycle expected-output queue, plus timeout, reset and halt sequences.
module tb_cpu_control_unit;

  logic clk;
  logic rst_n;

  cpu_control_unit_if #(.CNT_W(8)) bus ();
  cpu_control_unit_if #(.CNT_W(2)) bus2 ();

  assign bus2.run       = bus.run;
  assign bus2.ir_op     = bus.ir_op;
  assign bus2.zero_flag = bus.zero_flag;
  assign bus2.mem_ready = bus.mem_ready;

  cpu_control_unit #(.MEM_TIMEOUT(15), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  cpu_control_unit #(.MEM_TIMEOUT(15), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_re, ir_re, opr_re, pc_inc, pc_load, acc_we, alu_op[2:0], out_we, halted}
  localparam logic [10:0] W_ZERO = 11'h000;
  localparam logic [10:0] W_MEM  = 11'h400;
  localparam logic [10:0] W_LDIR = 11'h280;
  localparam logic [10:0] W_LDOP = 11'h180;
  localparam logic [10:0] W_HALT = 11'h001;

  logic [10:0] act_w;
  assign act_w = {bus.mem_re, bus.ir_re, bus.opr_re, bus.pc_inc, bus.pc_load,
                  bus.acc_we, bus.alu_op, bus.out_we, bus.halted};

  typedef struct {
    logic [3:0]  op;
    logic        zf;
    logic        opr;
    logic [10:0] exec_w;
    logic        ill;
  } vec_t;

  vec_t        vecs [18];
  logic [10:0] exp_q [$];
  logic [7:0]  exp_cnt;
  int          checks;
  int          errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_out", 32'(act_w), 32'(W_ZERO));
    chk("rst_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("rst_ill", 32'(bus.illegal), 32'd0);
    chk("rst_berr", 32'(bus.bus_err), 32'd0);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic run_instr(input vec_t v);
    logic [10:0] e;
    bus.ir_op = v.op; bus.zero_flag = v.zf; bus.mem_ready = 1'b1; bus.run = 1'b1;
    exp_q.push_back(W_MEM);
    exp_q.push_back(W_LDIR);
    exp_q.push_back(W_ZERO);
    if (v.opr) begin
      exp_q.push_back(W_MEM);
      exp_q.push_back(W_LDOP);
    end
    exp_q.push_back(v.exec_w);
    tick();
    bus.run = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("seq_op%h_z%0d", v.op, v.zf), 32'(act_w), 32'(e));
      tick();
    end
    exp_cnt++;
    chk($sformatf("cnt_op%h", v.op), 32'(bus.instr_cnt), 32'(exp_cnt));
    chk($sformatf("cnt2_op%h", v.op), 32'(bus2.instr_cnt), 32'(exp_cnt[1:0]));
    chk($sformatf("ill_op%h", v.op), 32'(bus.illegal), 32'(v.ill));
    chk($sformatf("idle_op%h", v.op), 32'(act_w), 32'(W_ZERO));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] pat [4];
    logic [1:0]  small_seq [5];
    int          pc_pulses;

    checks = 0; errors = 0; exp_cnt = '0;
    bus.run = 1'b0; bus.ir_op = 4'h0; bus.zero_flag = 1'b0; bus.mem_ready = 1'b0;

    vecs[0]  = '{4'h0, 1'b0, 1'b0, 11'h000, 1'b0};
    vecs[1]  = '{4'h1, 1'b0, 1'b1, 11'h020, 1'b0};
    vecs[2]  = '{4'h2, 1'b0, 1'b1, 11'h024, 1'b0};
    vecs[3]  = '{4'h3, 1'b1, 1'b1, 11'h028, 1'b0};
    vecs[4]  = '{4'h4, 1'b0, 1'b1, 11'h02C, 1'b0};
    vecs[5]  = '{4'h5, 1'b0, 1'b1, 11'h030, 1'b0};
    vecs[6]  = '{4'h6, 1'b0, 1'b1, 11'h034, 1'b0};
    vecs[7]  = '{4'h7, 1'b0, 1'b0, 11'h038, 1'b0};
    vecs[8]  = '{4'h8, 1'b0, 1'b1, 11'h040, 1'b0};
    vecs[9]  = '{4'h9, 1'b1, 1'b1, 11'h040, 1'b0};
    vecs[10] = '{4'h9, 1'b0, 1'b1, 11'h000, 1'b0};
    vecs[11] = '{4'hA, 1'b0, 1'b0, 11'h002, 1'b0};
    vecs[12] = '{4'hC, 1'b0, 1'b0, 11'h000, 1'b1};
    vecs[13] = '{4'h0, 1'b0, 1'b0, 11'h000, 1'b1};
    vecs[14] = '{4'hB, 1'b0, 1'b0, 11'h000, 1'b1};
    vecs[15] = '{4'hD, 1'b1, 1'b0, 11'h000, 1'b1};
    vecs[16] = '{4'hE, 1'b0, 1'b0, 11'h000, 1'b1};
    vecs[17] = '{4'h0, 1'b0, 1'b0, 11'h000, 1'b1};

    pat[0] = W_MEM; pat[1] = W_LDIR; pat[2] = W_ZERO; pat[3] = W_ZERO;
    small_seq[0] = 2'd1; small_seq[1] = 2'd2; small_seq[2] = 2'd3;
    small_seq[3] = 2'd0; small_seq[4] = 2'd1;

    rst_n = 1'b0;
    tick();
    do_reset();

    // Back-to-back NOPs with run held high; 2-bit counter must wrap.
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.ir_op = 4'h0;
    tick();
    pc_pulses = 0;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("nop_c%0d", c), 32'(act_w), 32'(pat[c % 4]));
      if (c < 12 && bus.pc_inc) pc_pulses++;
      if (c == 19) bus.run = 1'b0;
      tick();
      if (c % 4 == 3) chk($sformatf("cnt2_nop%0d", c / 4), 32'(bus2.instr_cnt), 32'(small_seq[c / 4]));
      if (c == 11) chk("cnt_after12", 32'(bus.instr_cnt), 32'd3);
    end
    chk("pc_inc_pulses", 32'(pc_pulses), 32'd3);
    chk("nop_idle", 32'(act_w), 32'(W_ZERO));
    exp_cnt = 8'd5;

    for (int i = 0; i < 18; i++) run_instr(vecs[i]);

    do_reset();

    // mem_ready never arrives: HALT after the 15th fetch wait cycle.
    bus.run = 1'b1; bus.mem_ready = 1'b0; bus.ir_op = 4'h0;
    tick();
    bus.run = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("to_fetch%0d", k + 1), 32'(act_w), 32'(W_MEM));
      tick();
    end
    chk("to_halted", 32'(act_w), 32'(W_HALT));
    chk("to_berr", 32'(bus.bus_err), 32'd1);
    chk("to_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    for (int k = 0; k < 4; k++) begin
      bus.run = k[0];
      tick();
      chk($sformatf("to_stay%0d", k), 32'(act_w), 32'(W_HALT));
    end
    bus.run = 1'b0;
    do_reset();

    // mem_ready on the 15th wait cycle is still accepted.
    bus.run = 1'b1; bus.mem_ready = 1'b0; bus.ir_op = 4'h0;
    tick();
    bus.run = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    bus.mem_ready = 1'b1;
    chk("late_fetch15", 32'(act_w), 32'(W_MEM));
    tick();
    chk("late_ldir", 32'(act_w), 32'(W_LDIR));
    chk("late_berr", 32'(bus.bus_err), 32'd0);
    tick();
    chk("late_decode", 32'(act_w), 32'(W_ZERO));
    tick();
    tick();
    exp_cnt++;
    chk("late_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    chk("late_idle", 32'(act_w), 32'(W_ZERO));

    // Reset while waiting in OPFETCH.
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.ir_op = 4'h2;
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    chk("opf_mem_re", 32'(act_w), 32'(W_MEM));
    do_reset();
    tick();
    chk("opf_idle", 32'(act_w), 32'(W_ZERO));

    // HLT retires and then holds regardless of run.
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.ir_op = 4'hF;
    exp_q.push_back(W_MEM);
    exp_q.push_back(W_LDIR);
    exp_q.push_back(W_ZERO);
    exp_q.push_back(W_ZERO);
    tick();
    while (exp_q.size() > 0) begin
      chk("hlt_seq", 32'(act_w), 32'(exp_q.pop_front()));
      tick();
    end
    exp_cnt++;
    chk("hlt_halted", 32'(act_w), 32'(W_HALT));
    chk("hlt_cnt", 32'(bus.instr_cnt), 32'(exp_cnt));
    for (int k = 0; k < 4; k++) begin
      bus.run = ~bus.run;
      tick();
      chk($sformatf("hlt_stay%0d", k), 32'(act_w), 32'(W_HALT));
    end
    bus.run = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
